frv_trap_sequencer: RTL and testbench

FRV_TRAP_SEQUENCER -- requirements
Module: frv_trap_sequencer

---
 rtl/frv_trap_sequencer_if.sv | 43 ++++
 rtl/frv_trap_sequencer.sv | 126 ++++++++++++
 tb/tb_frv_trap_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frv_trap_sequencer_if.sv
// Bundle for the frv_trap_sequencer: writeback trap, MRET and interrupt requests,
// CSR inputs, the CSR trap-update port, and the control-flow handshake to fetch.
// The master side drives requests and CSR values. The slave side is the sequencer.
interface frv_trap_sequencer_if;
  logic        exc_req;
  logic [5:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_mtval;
  logic        mret_req;
  logic        int_pend;
  logic        int_en;
  logic        int_pc_valid;
  logic [31:0] int_pc;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        busy;
  logic        exc_done;
  logic        trap_wen;
  logic        trap_int;
  logic [5:0]  trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_mtval;
  logic        mret_wen;
  logic        cf_req;
  logic [31:0] cf_target;
  logic        cf_ack;

  modport slave (
    input  exc_req, exc_cause, exc_pc, exc_mtval, mret_req,
    input  int_pend, int_en, int_pc_valid, int_pc,
    input  csr_mtvec, csr_mepc, cf_ack,
    output busy, exc_done, trap_wen, trap_int, trap_cause, trap_pc, trap_mtval,
    output mret_wen, cf_req, cf_target
  );

  modport master (
    output exc_req, exc_cause, exc_pc, exc_mtval, mret_req,
    output int_pend, int_en, int_pc_valid, int_pc,
    output csr_mtvec, csr_mepc, cf_ack,
    input  busy, exc_done, trap_wen, trap_int, trap_cause, trap_pc, trap_mtval,
    input  mret_wen, cf_req, cf_target
  );
endinterface

// File: rtl/frv_trap_sequencer.sv
// Trap sequencer: it arbitrates exceptions, MRET and interrupts in IDLE.
// A trap writes the CSR trap fields in UPD. An MRET restores MIE in MRET.
// CF then redirects fetch and holds the request until fetch acknowledges it.
// exc_done is decoded from cf_ack in the ack cycle.
// This lets the held exc_req/mret_req drop before the next IDLE arbitration.
module frv_trap_sequencer (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  frv_trap_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UPD  = 2'd1,
    ST_MRET = 2'd2,
    ST_CF   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mtval_q, mtval_d;
  logic        int_q, int_d;
  logic        done_q, done_d;      // operation reports exc_done on ack
  logic [31:0] target_q, target_d;

  logic [31:0] base_s;
  logic        vectored_s;
  logic        int_take_s;
  logic        unused_mepc_lsb_s;

  assign base_s            = {bus.csr_mtvec[31:2], 2'b00};
  assign vectored_s        = (bus.csr_mtvec[1:0] == 2'b01) && int_q;
  assign int_take_s        = bus.int_pend && bus.int_en && bus.int_pc_valid;
  assign unused_mepc_lsb_s = bus.csr_mepc[0];

  // Next-state and latched-field computation for the sequencer FSM
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    pc_d     = pc_q;
    mtval_d  = mtval_q;
    int_d    = int_q;
    done_d   = done_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.exc_req) begin
          cause_d = bus.exc_cause;
          pc_d    = bus.exc_pc;
          mtval_d = bus.exc_mtval;
          int_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_UPD;
        end else if (bus.mret_req) begin
          done_d  = 1'b1;
          state_d = ST_MRET;
        end else if (int_take_s) begin
          cause_d = 6'd11;
          pc_d    = bus.int_pc;
          mtval_d = 32'd0;
          int_d   = 1'b1;
          done_d  = 1'b0;
          state_d = ST_UPD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPD: begin
        if (vectored_s) begin
          target_d = base_s + {24'd0, cause_q, 2'b00};
        end else begin
          target_d = base_s;
        end
        state_d = ST_CF;
      end
      ST_MRET: begin
        target_d = {bus.csr_mepc[31:1], 1'b0};
        state_d  = ST_CF;
      end
      ST_CF: begin
        if (bus.cf_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CF;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-field registers with synchronous active-low reset
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q  <= ST_IDLE;
      cause_q  <= 6'd0;
      pc_q     <= 32'd0;
      mtval_q  <= 32'd0;
      int_q    <= 1'b0;
      done_q   <= 1'b0;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      pc_q     <= pc_d;
      mtval_q  <= mtval_d;
      int_q    <= int_d;
      done_q   <= done_d;
      target_q <= target_d;
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.trap_wen   = (state_q == ST_UPD);
  assign bus.mret_wen   = (state_q == ST_MRET);
  assign bus.cf_req     = (state_q == ST_CF);
  assign bus.exc_done   = (state_q == ST_CF) && bus.cf_ack && done_q;
  assign bus.trap_int   = int_q;
  assign bus.trap_cause = cause_q;
  assign bus.trap_pc    = pc_q;
  assign bus.trap_mtval = mtval_q;
  assign bus.cf_target  = target_q;

endmodule

// File: tb/tb_frv_trap_sequencer.sv
// Directed bench for frv_trap_sequencer.
// The bench drives inputs 1 time unit after the rising edge and checks outputs on the falling edge.
module tb_frv_trap_sequencer;

  logic g_clk;
  logic g_resetn;
  int   n_checks;
  int   n_fail;

  frv_trap_sequencer_if bus ();

  frv_trap_sequencer dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge g_clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge g_clk);
  endtask

  task automatic clear_inputs();
    bus.exc_req      = 1'b0;
    bus.exc_cause    = 6'd0;
    bus.exc_pc       = 32'd0;
    bus.exc_mtval    = 32'd0;
    bus.mret_req     = 1'b0;
    bus.int_pend     = 1'b0;
    bus.int_en       = 1'b0;
    bus.int_pc_valid = 1'b0;
    bus.int_pc       = 32'd0;
    bus.cf_ack       = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    bus.csr_mtvec = 32'd0;
    bus.csr_mepc  = 32'd0;
    g_resetn = 1'b0;
    next_cycle();
    next_cycle();
    g_resetn = 1'b1;

    // Reset state
    at_sample();
    check_value("rst_busy", bus.busy, 32'd0);
    check_value("rst_cf_req", bus.cf_req, 32'd0);
    check_value("rst_trap_wen", bus.trap_wen, 32'd0);
    check_value("rst_mret_wen", bus.mret_wen, 32'd0);
    check_value("rst_exc_done", bus.exc_done, 32'd0);
    check_value("rst_cf_target", bus.cf_target, 32'd0);
    check_value("rst_trap_pc", bus.trap_pc, 32'd0);

    // cf_ack while cf_req is low must be ignored
    next_cycle();
    bus.cf_ack = 1'b1;
    at_sample();
    check_value("stray_ack_done", bus.exc_done, 32'd0);
    next_cycle();
    bus.cf_ack = 1'b0;
    check_value("stray_ack_busy", bus.busy, 32'd0);

    // Exception: cause 2, direct mtvec, ack delayed three cycles
    bus.csr_mtvec = 32'h0000_8000;
    bus.exc_req   = 1'b1;
    bus.exc_cause = 6'd2;
    bus.exc_pc    = 32'h0000_0100;
    bus.exc_mtval = 32'h0000_DEAD;
    at_sample();
    check_value("exc_idle_wen", bus.trap_wen, 32'd0);
    next_cycle();
    at_sample();
    check_value("exc_trap_wen", bus.trap_wen, 32'd1);
    check_value("exc_cause", bus.trap_cause, 32'd2);
    check_value("exc_pc", bus.trap_pc, 32'h100);
    check_value("exc_mtval", bus.trap_mtval, 32'hDEAD);
    check_value("exc_int", bus.trap_int, 32'd0);
    check_value("exc_upd_cf_req", bus.cf_req, 32'd0);
    check_value("exc_busy", bus.busy, 32'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      at_sample();
      check_value("exc_cf_req_hold", bus.cf_req, 32'd1);
      check_value("exc_target_hold", bus.cf_target, 32'h8000);
      check_value("exc_no_done_yet", bus.exc_done, 32'd0);
      check_value("exc_cf_trap_wen", bus.trap_wen, 32'd0);
    end
    next_cycle();
    bus.cf_ack = 1'b1;
    at_sample();
    check_value("exc_done_pulse", bus.exc_done, 32'd1);
    check_value("exc_ack_target", bus.cf_target, 32'h8000);
    next_cycle();
    clear_inputs();
    at_sample();
    check_value("exc_after_busy", bus.busy, 32'd0);
    check_value("exc_after_done", bus.exc_done, 32'd0);
    check_value("exc_after_cf_req", bus.cf_req, 32'd0);
    check_value("exc_target_kept", bus.cf_target, 32'h8000);

    // Vectored interrupt: mtvec mode 01, cause 11 -> base + 0x2C
    next_cycle();
    bus.csr_mtvec    = 32'h0000_8001;
    bus.int_pend     = 1'b1;
    bus.int_en       = 1'b1;
    bus.int_pc_valid = 1'b1;
    bus.int_pc       = 32'h0000_0204;
    next_cycle();
    bus.int_pend = 1'b0;
    at_sample();
    check_value("int_trap_wen", bus.trap_wen, 32'd1);
    check_value("int_cause", bus.trap_cause, 32'd11);
    check_value("int_flag", bus.trap_int, 32'd1);
    check_value("int_pc", bus.trap_pc, 32'h204);
    check_value("int_mtval", bus.trap_mtval, 32'd0);
    next_cycle();
    bus.cf_ack = 1'b1;
    at_sample();
    check_value("int_cf_req", bus.cf_req, 32'd1);
    check_value("int_target", bus.cf_target, 32'h802C);
    check_value("int_no_done", bus.exc_done, 32'd0);
    next_cycle();
    clear_inputs();
    at_sample();
    check_value("int_after_busy", bus.busy, 32'd0);

    // MRET: mepc bit 0 cleared, no trap_wen
    next_cycle();
    bus.csr_mepc = 32'h0000_0307;
    bus.mret_req = 1'b1;
    next_cycle();
    at_sample();
    check_value("mret_wen", bus.mret_wen, 32'd1);
    check_value("mret_trap_wen", bus.trap_wen, 32'd0);
    next_cycle();
    bus.cf_ack = 1'b1;
    at_sample();
    check_value("mret_cf_req", bus.cf_req, 32'd1);
    check_value("mret_target", bus.cf_target, 32'h306);
    check_value("mret_done", bus.exc_done, 32'd1);
    check_value("mret_cf_trap_wen", bus.trap_wen, 32'd0);
    next_cycle();
    clear_inputs();
    at_sample();
    check_value("mret_after_busy", bus.busy, 32'd0);

    // Vectored target wraps modulo 2^32
    next_cycle();
    bus.csr_mtvec    = 32'hFFFF_FFFD;
    bus.int_pend     = 1'b1;
    bus.int_en       = 1'b1;
    bus.int_pc_valid = 1'b1;
    bus.int_pc       = 32'h0000_0A00;
    next_cycle();
    bus.int_pend = 1'b0;
    next_cycle();
    bus.cf_ack = 1'b1;
    at_sample();
    check_value("wrap_target", bus.cf_target, 32'h0000_0028);
    next_cycle();
    clear_inputs();

    // Collision: exception wins, interrupt taken in the cycle after the ack
    bus.csr_mtvec    = 32'h0000_8001;
    bus.exc_req      = 1'b1;
    bus.exc_cause    = 6'd3;
    bus.exc_pc       = 32'h0000_0400;
    bus.exc_mtval    = 32'h0000_0011;
    bus.int_pend     = 1'b1;
    bus.int_en       = 1'b1;
    bus.int_pc_valid = 1'b1;
    bus.int_pc       = 32'h0000_0500;
    next_cycle();
    at_sample();
    check_value("col_exc_int", bus.trap_int, 32'd0);
    check_value("col_exc_cause", bus.trap_cause, 32'd3);
    check_value("col_exc_pc", bus.trap_pc, 32'h400);
    next_cycle();
    bus.cf_ack = 1'b1;
    at_sample();
    check_value("col_exc_target", bus.cf_target, 32'h8000);
    check_value("col_exc_done", bus.exc_done, 32'd1);
    next_cycle();
    bus.exc_req = 1'b0;
    bus.cf_ack  = 1'b0;
    at_sample();
    check_value("col_idle_busy", bus.busy, 32'd0);
    next_cycle();
    bus.int_pend = 1'b0;
    at_sample();
    check_value("col_int_wen", bus.trap_wen, 32'd1);
    check_value("col_int_flag", bus.trap_int, 32'd1);
    check_value("col_int_cause", bus.trap_cause, 32'd11);
    check_value("col_int_pc", bus.trap_pc, 32'h500);
    next_cycle();
    bus.cf_ack = 1'b1;
    at_sample();
    check_value("col_int_target", bus.cf_target, 32'h802C);
    check_value("col_int_no_done", bus.exc_done, 32'd0);
    next_cycle();
    clear_inputs();

    // Reset while in CF aborts the operation
    bus.csr_mtvec = 32'h0000_8000;
    bus.exc_req   = 1'b1;
    bus.exc_cause = 6'd5;
    bus.exc_pc    = 32'h0000_0600;
    next_cycle();
    next_cycle();
    at_sample();
    check_value("rcf_cf_req", bus.cf_req, 32'd1);
    next_cycle();
    g_resetn    = 1'b0;
    bus.exc_req = 1'b0;
    next_cycle();
    g_resetn = 1'b1;
    at_sample();
    check_value("rcf_cf_req_drop", bus.cf_req, 32'd0);
    check_value("rcf_busy", bus.busy, 32'd0);
    check_value("rcf_done", bus.exc_done, 32'd0);
    check_value("rcf_target", bus.cf_target, 32'd0);
    check_value("rcf_trap_pc", bus.trap_pc, 32'd0);
    check_value("rcf_cause", bus.trap_cause, 32'd0);
    next_cycle();
    bus.exc_req   = 1'b1;
    bus.exc_cause = 6'd7;
    bus.exc_pc    = 32'h0000_0700;
    bus.exc_mtval = 32'h0000_0077;
    next_cycle();
    at_sample();
    check_value("rcf_new_wen", bus.trap_wen, 32'd1);
    check_value("rcf_new_pc", bus.trap_pc, 32'h700);
    check_value("rcf_new_cause", bus.trap_cause, 32'd7);
    next_cycle();
    bus.cf_ack = 1'b1;
    at_sample();
    check_value("rcf_new_target", bus.cf_target, 32'h8000);
    check_value("rcf_new_done", bus.exc_done, 32'd1);
    next_cycle();
    clear_inputs();
    at_sample();
    check_value("rcf_new_idle", bus.busy, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
